// File: rtl/cipher_framer.sv
// -----------------------------------------------------------------------------
// cipher_framer
//   Buffers ciphertext bytes from the RC4 encryptor in a small FIFO and sends
//   them out as framed packets: SYNC, LEN, payload bytes, then an XOR checksum.
//   The output side uses a valid/ready handshake towards a back-pressured link.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-low reset
//   in_valid     ciphertext byte strobe
//   in_data      ciphertext byte
//   flush        one-cycle pulse: close the current frame with what is buffered
//   in_full      FIFO holds DEPTH bytes (combinational from the count)
//   overflow     sticky: a byte was dropped because the FIFO was full
//   out_valid    out_data holds a valid frame byte
//   out_data     frame byte (0 while out_valid is low)
//   out_ready    downstream accepts out_data this cycle
//   frame_busy   frame in progress (FSM not idle)
//   frames_sent  completed frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module cipher_framer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [7:0]  SYNC      = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       flush,
    output logic       in_full,
    output logic       overflow,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       frame_busy,
    output logic [7:0] frames_sent
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FLEN_C  = CW'(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CHK
    } state_e;

    // FIFO storage and pointers
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Frame control
    state_e     state_q,      state_d;
    logic [7:0] len_q,        len_d;
    logic [7:0] rem_q,        rem_d;
    logic [7:0] chk_q,        chk_d;
    logic       flush_pend_q, flush_pend_d;

    // Registered outputs
    logic       overflow_q,  overflow_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q,  out_data_d;
    logic [7:0] frames_q,    frames_d;

    // Handshake / FIFO strobes
    logic       xfer_c;
    logic       push_c;
    logic       pop_c;
    logic       start_c;
    logic [7:0] start_len_c;
    logic [7:0] head_c;
    logic [7:0] next_head_c;

    assign xfer_c = out_valid_q & out_ready;
    assign pop_c  = xfer_c && (state_q == S_PAY);
    // A full FIFO refuses the byte even when a pop happens in the same cycle.
    assign push_c = in_valid && (count_q != DEPTH_C);

    assign head_c      = mem_q[rd_ptr_q];
    // While in PAY with more than one byte left, the FIFO holds at least two
    // bytes, so the entry after the head is already written.
    assign next_head_c = mem_q[rd_ptr_q + AW'(1)];

    assign start_c = (state_q == S_IDLE) &&
                     ((count_q >= FLEN_C) || (flush_pend_q && (count_q != '0)));
    assign start_len_c = (count_q >= FLEN_C) ? 8'(FRAME_LEN) : 8'(count_q);

    // FIFO write port; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        overflow_d = overflow_q | (in_valid && (count_q == DEPTH_C));
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Framing FSM next state; outputs are computed for the state being entered
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rem_d        = rem_q;
        chk_d        = chk_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frames_d     = frames_q;
        flush_pend_d = flush_pend_q | flush;

        unique case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
                if (start_c) begin
                    len_d        = start_len_c;
                    rem_d        = start_len_c;
                    chk_d        = 8'h00;
                    state_d      = S_SYNC;
                    out_valid_d  = 1'b1;
                    out_data_d   = SYNC;
                    flush_pend_d = 1'b0;
                end else if (count_q == '0) begin
                    // Nothing to close: an empty frame is never sent.
                    flush_pend_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (xfer_c) begin
                    state_d    = S_LEN;
                    out_data_d = len_q;
                end
            end
            S_LEN: begin
                if (xfer_c) begin
                    state_d    = S_PAY;
                    out_data_d = head_c;
                end
            end
            S_PAY: begin
                if (xfer_c) begin
                    chk_d = chk_q ^ head_c;
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d    = S_CHK;
                        out_data_d = chk_q ^ head_c;
                    end else begin
                        out_data_d = next_head_c;
                    end
                end
            end
            S_CHK: begin
                if (xfer_c) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                    frames_d    = frames_q + 8'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            len_q        <= 8'h00;
            rem_q        <= 8'h00;
            chk_q        <= 8'h00;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            frames_q     <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            chk_q        <= chk_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frames_q     <= frames_d;
        end
    end

    assign in_full     = (count_q == DEPTH_C);
    assign overflow    = overflow_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign frame_busy  = (state_q != S_IDLE);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_cipher_framer.sv
// -----------------------------------------------------------------------------
// tb_cipher_framer
//   Self-checking bench for cipher_framer. A frame-level model (byte queues)
//   predicts every output each cycle; literal frame contents pin the model.
// -----------------------------------------------------------------------------
module tb_cipher_framer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned FLEN  = 8;
    localparam logic [7:0]  SYNCB = 8'h7E;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       flush;
    logic       in_full;
    logic       overflow;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       frame_busy;
    logic [7:0] frames_sent;

    always #5 clk = ~clk;

    cipher_framer #(
        .DEPTH    (DEPTH),
        .FRAME_LEN(FLEN),
        .SYNC     (SYNCB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .in_full    (in_full),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_busy (frame_busy),
        .frames_sent(frames_sent)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mfifo [$];   // buffered bytes, head at index 0
    logic [7:0] mframe[$];   // bytes still to send for the active frame
    int         mpos;        // index of mframe[0] within the frame
    int         mlen;
    bit         mpend;
    bit         movf;
    int         mframes;
    bit         model_on = 1'b0;

    logic [7:0] log_q[$];    // every transferred byte
    int         cyc = 0;
    int         sync_cyc = -1;

    always @(negedge clk) begin
        int         pre;
        bit         clr;
        logic [7:0] x;
        logic [7:0] tmp;
        bit         ev;

        if (model_on) begin
            ev = (mframe.size() > 0);
            chk("out_valid",   32'(out_valid),   32'(ev));
            chk("out_data",    32'(out_data),    ev ? 32'(mframe[0]) : 32'h0);
            chk("frame_busy",  32'(frame_busy),  32'(ev));
            chk("in_full",     32'(in_full),     32'(mfifo.size() == DEPTH));
            chk("overflow",    32'(overflow),    32'(movf));
            chk("frames_sent", 32'(frames_sent), 32'(mframes % 256));
        end

        if (out_valid === 1'b1 && sync_cyc < 0) sync_cyc = cyc;
        if (out_valid === 1'b1 && out_ready) log_q.push_back(out_data);

        if (!rst) begin
            mfifo.delete();
            mframe.delete();
            mpos    = 0;
            mlen    = 0;
            mpend   = 1'b0;
            movf    = 1'b0;
            mframes = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            pre = mfifo.size();
            clr = 1'b0;
            if (mframe.size() > 0) begin
                if (out_ready) begin
                    if (mpos >= 2 && mpos < mlen + 2) tmp = mfifo.pop_front();
                    tmp = mframe.pop_front();
                    mpos++;
                    if (mframe.size() == 0) mframes++;
                end
            end else begin
                if (pre >= FLEN || (mpend && pre > 0)) begin
                    mlen = (pre >= FLEN) ? FLEN : pre;
                    mframe.push_back(SYNCB);
                    mframe.push_back(8'(mlen));
                    x = 8'h00;
                    for (int i = 0; i < mlen; i++) begin
                        mframe.push_back(mfifo[i]);
                        x ^= mfifo[i];
                    end
                    mframe.push_back(x);
                    mpos = 0;
                    clr  = 1'b1;
                end else if (pre == 0) begin
                    clr = 1'b1;
                end
            end
            mpend = clr ? 1'b0 : (mpend | flush);
            if (in_valid) begin
                if (pre < DEPTH) mfifo.push_back(in_data);
                else             movf = 1'b1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int limit, input string name);
        int k = 0;
        while (log_q.size() < n && k < limit) begin
            step();
            k++;
        end
        chk(name, 32'(log_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [7:0] exp1 [11] = '{8'h7E, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    logic [7:0] exp2 [6]  = '{8'h7E, 8'h03, 8'hAA, 8'h55, 8'h0F, 8'hF0};
    logic [7:0] exp4 [22] = '{8'h7E, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h08,
                              8'h7E, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                              8'h0F, 8'h10, 8'h18};
    logic [7:0] exp5 [11] = '{8'h7E, 8'h08, 8'hC1, 8'hC2, 8'hC3, 8'hC4,
                              8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'h08};
    logic [7:0] b2 [3]    = '{8'hAA, 8'h55, 8'h0F};

    initial begin
        int push_cyc;
        int k;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;

        // Reset state
        chk("rst_out_valid",   32'(out_valid),   32'h0);
        chk("rst_out_data",    32'(out_data),    32'h0);
        chk("rst_in_full",     32'(in_full),     32'h0);
        chk("rst_overflow",    32'(overflow),    32'h0);
        chk("rst_frame_busy",  32'(frame_busy),  32'h0);
        chk("rst_frames_sent", 32'(frames_sent), 32'h0);

        // 1: full frame, out_ready high, latency check
        out_ready = 1'b1;
        log_q.delete();
        sync_cyc = -1;
        push_cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (i == 8) push_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
        wait_log(11, 100, "s1_wait");
        for (int i = 0; i < 11; i++)
            if (i < log_q.size()) chk($sformatf("s1_byte%0d", i), 32'(log_q[i]), 32'(exp1[i]));
        chk("s1_latency", 32'(sync_cyc - push_cyc), 32'd2);
        step();
        chk("s1_frames_sent", 32'(frames_sent), 32'd1);

        // 2: flushed short frame, then flush on empty FIFO
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = b2[i];
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        wait_log(6, 100, "s2_wait");
        for (int i = 0; i < 6; i++)
            if (i < log_q.size()) chk($sformatf("s2_byte%0d", i), 32'(log_q[i]), 32'(exp2[i]));
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("s2_empty_busy", 32'(frame_busy), 32'h0);
            step();
        end
        chk("s2_no_output", 32'(log_q.size()), 32'd6);

        // 3: back-pressure with random out_ready
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(i);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        k = 0;
        while (log_q.size() < 11 && k < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        chk("s3_wait", 32'(log_q.size()), 32'd11);
        for (int i = 0; i < 11; i++)
            if (i < log_q.size()) chk($sformatf("s3_byte%0d", i), 32'(log_q[i]), 32'(exp1[i]));
        out_ready = 1'b1;
        step();
        step();

        // 4: overflow with stalled output
        log_q.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            if (i == 15) chk("s4_not_full15", 32'(in_full), 32'h0);
            if (i == 16) chk("s4_full16",     32'(in_full), 32'h1);
        end
        in_valid = 1'b0;
        chk("s4_overflow", 32'(overflow), 32'h1);
        out_ready = 1'b1;
        wait_log(22, 200, "s4_wait");
        for (int i = 0; i < 22; i++)
            if (i < log_q.size()) chk($sformatf("s4_byte%0d", i), 32'(log_q[i]), 32'(exp4[i]));
        chk("s4_overflow_sticky", 32'(overflow), 32'h1);
        step();

        // 5: reset in the middle of the payload
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
        wait_log(5, 100, "s5_wait_pay");
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("s5_out_valid",   32'(out_valid),   32'h0);
        chk("s5_in_full",     32'(in_full),     32'h0);
        chk("s5_frames_sent", 32'(frames_sent), 32'h0);
        chk("s5_overflow",    32'(overflow),    32'h0);
        chk("s5_busy",        32'(frame_busy),  32'h0);
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        wait_log(11, 100, "s5_wait_new");
        for (int i = 0; i < 11; i++)
            if (i < log_q.size()) chk($sformatf("s5_byte%0d", i), 32'(log_q[i]), 32'(exp5[i]));
        step();

        // 6: random traffic until 256 frames complete; counter wraps to 0
        do_reset();
        k = 0;
        while (mframes < 256 && k < 30000) begin
            in_valid  = ($urandom_range(0, 99) < 40);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < 80);
            flush     = ($urandom_range(0, 59) == 0);
            step();
            k++;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("s6_frames_done", 32'(mframes), 32'd256);
        chk("s6_wrap", 32'(frames_sent), 32'h0);
        out_ready = 1'b1;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cipher_framer.md
Name: cipher_framer

Overview:
Downstream stage of the RC4 encryptor. It buffers ciphertext bytes as they appear on the encryptor output strobe, then emits them as framed packets: SYNC byte, LEN byte, payload bytes, and an XOR checksum byte. Output uses a valid/ready handshake towards the serial/line interface. It decouples the encryptor's one-byte-per-keystream cadence from a back-pressured link.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, ≥ FRAME_LEN
FRAME_LEN, 8, maximum payload bytes per frame (1..255)
SYNC, 8'h7E, frame start byte

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous and active-low
in_valid  input  1  ciphertext byte strobe (encryptor output-ready)
in_data  input  8  ciphertext byte
flush  input  1  one-cycle pulse; close the current frame with whatever is buffered
in_full  output  1  FIFO holds DEPTH bytes
overflow  output  1  sticky; a byte was dropped because the FIFO was full
out_valid  output  1  out_data holds a valid frame byte
out_data  output  8  frame byte
out_ready  input  1  downstream accepts out_data this cycle
frame_busy  output  1  FSM not in IDLE
frames_sent  output  8  count of completed frames, wraps 255→0

Behaviour:
- Reset (rst=0 at an edge):
  - FIFO emptied; flush_pending, checksum, remaining and length registers cleared.
  - FSM goes to IDLE.
  - in_full=0, overflow=0, out_valid=0, out_data=0, frame_busy=0, frames_sent=0.
  - Reset mid-frame abandons the partial frame; bytes already transmitted are not recovered.
- FIFO push:
  - in_valid=1 and count<DEPTH → write in_data, count+1.
  - in_valid=1 and count==DEPTH → byte dropped, overflow set to 1 and held until reset. This applies even if a pop occurs the same cycle.
  - Simultaneous push and pop with count<DEPTH → count unchanged.
- in_full = (count==DEPTH), combinational from count.
- flush:
  - Sets flush_pending.
  - flush_pending clears when a frame starts, or at that same edge if the FIFO is empty in IDLE (empty frames are never sent).
- FSM states: IDLE, SYNC, LEN, PAY, CHK.
  - IDLE: out_valid=0. If count≥FRAME_LEN, or flush_pending and count>0:
    - latch len = min(count, FRAME_LEN);
    - remaining = len, chk = 0;
    - go to SYNC.
  - SYNC: out_valid=1, out_data=SYNC. On out_ready → LEN.
  - LEN: out_valid=1, out_data=len. On out_ready → PAY.
  - PAY: out_valid=1, out_data=FIFO head. On out_ready:
    - pop;
    - chk ^= head;
    - remaining−1;
    - if remaining was 1 → CHK.
  - CHK: out_valid=1, out_data=chk. On out_ready → IDLE and frames_sent+1.
- Handshake: a byte transfers on an edge with out_valid&&out_ready. While out_valid=1 and out_ready=0, out_data is held stable. out_valid never drops without a transfer, except on reset.
- out_data=0 whenever out_valid=0. frame_busy=1 in every state except IDLE.
- Latency: the byte that completes FRAME_LEN is presented with in_valid in cycle c. SYNC appears (out_valid=1) in cycle c+2 (write at end of c, FSM transition at end of c+1). With out_ready held high, a full frame takes FRAME_LEN+3 consecutive cycles.
- Bytes arriving during an active frame are buffered for the next frame. A frame's len is fixed at entry to SYNC.
- Back-to-back: CHK→IDLE, then at least one IDLE cycle before the next SYNC.

Test Plan:
1. out_ready=1; push 8'h01..8'h08 on consecutive cycles → out stream 7E,08,01,02,03,04,05,06,07,08,08; SYNC appears 2 cycles after the 8th push; frames_sent=1.
2. Push AA,55,0F, then pulse flush → 7E,03,AA,55,0F,F0; a subsequent flush with empty FIFO → no output, frame_busy stays 0.
3. Back-pressure: frame of 01..08 with out_ready toggling pseudo-randomly → identical byte sequence to scenario 1; out_data is constant across every stalled cycle.
4. Overflow: hold out_ready=0 and push 17 bytes 01..11h.
   - in_full=1 after the 16th push; the 17th is dropped; overflow=1.
   - Then set out_ready=1 → two frames: payload 01..08 with chk 08, then payload 09..10h with chk 18h. overflow remains 1.
5. Reset mid-PAY: assert rst=0 after 3 payload bytes transferred → next cycle out_valid=0, in_full=0, frames_sent=0, FIFO empty. New bytes after reset frame normally.
6. Send 256 full frames → frames_sent counts up and wraps to 0 after the 256th CHK transfer.
